// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port synchronous SRAM between three requesters: the core
// data port (loads/stores), the MAC coprocessor operand read port and the core
// instruction fetch port. The grant is made combinationally on the current
// cycle's requests. It is registered so that each ack lines up with the SRAM
// read data, which returns one cycle after mem_en.
//
// Parameters
//   AW        address width of every port
//   MAX_WAIT  consecutive denied instr_req cycles before fetch is forced to
//             top priority for one cycle; 0 disables the boost
//
// Ports
//   clk, rstz                    clock, asynchronous active-low reset
//   instr_req/addr               fetch request (level) and address
//   instr_data/ack               fetch read data, valid with instr_ack
//   data_req/addr/wr_en/mask/wr_data   load/store request
//   data_rd_data/ack             load data (0 for a store ack) and completion
//   mac_req/addr                 MAC operand read request
//   mac_rdata/ack                MAC read data and completion
//   mem_en/wr_en/addr/wdata/mask SRAM command, driven from the granted port
//   mem_rdata                    SRAM read data, one cycle after mem_en
//
// Optional build macro MEM_ARB_STATS_EN adds:
//   stat_clr                     synchronous clear of the stall counters
//   stat_instr_stall/data_stall/mac_stall
//                                saturating 32-bit counts of cycles in which
//                                the port requested but was not granted
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int AW       = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          rstz,
  // instruction fetch port
  input  logic          instr_req,
  input  logic [AW-1:0] instr_addr,
  output logic [31:0]   instr_data,
  output logic          instr_ack,
  // core data port
  input  logic          data_req,
  input  logic [AW-1:0] data_addr,
  input  logic          data_wr_en,
  input  logic [3:0]    data_mask,
  input  logic [31:0]   data_wr_data,
  output logic [31:0]   data_rd_data,
  output logic          data_ack,
  // MAC coprocessor read port
  input  logic          mac_req,
  input  logic [AW-1:0] mac_addr,
  output logic [31:0]   mac_rdata,
  output logic          mac_ack,
  // SRAM side
  output logic          mem_en,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_mask,
`ifdef MEM_ARB_STATS_EN
  input  logic          stat_clr,
  output logic [31:0]   stat_instr_stall,
  output logic [31:0]   stat_data_stall,
  output logic [31:0]   stat_mac_stall,
`endif
  input  logic [31:0]   mem_rdata
);

  // Request/ack protocol, identical on all three ports:
  //   req is a level. Every cycle in which req is high and the port wins the
  //   grant is one complete transaction. Its ack (and read data) appears
  //   exactly one cycle later. A port that keeps req high through its ack
  //   cycle is issuing a new back-to-back request, not extending the old one.
  //   A denied request simply stays high until it is granted.

  // One-hot grant bit positions (data, mac, instr).
  localparam int G_DATA  = 2;
  localparam int G_MAC   = 1;
  localparam int G_INSTR = 0;

  // The starvation counter needs at least one bit even when the boost is off.
  localparam int SW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [SW-1:0] WAIT_MAX = SW'(MAX_WAIT);
  localparam bit BOOST_EN = (MAX_WAIT != 0);

  logic [2:0]    gnt;
  logic [2:0]    gnt_q;
  logic          store_q;
  logic [SW-1:0] starve_cnt;
  logic          boost;

  // ---------------------------------------------------------------------------
  // Grant selection
  // ---------------------------------------------------------------------------
  always_comb begin
    boost = BOOST_EN && (starve_cnt == WAIT_MAX);
    gnt   = 3'b000;
    if (boost && instr_req) begin
      // A starved fetch jumps ahead of both data and MAC for this cycle.
      gnt[G_INSTR] = 1'b1;
    end else if (data_req) begin
      gnt[G_DATA] = 1'b1;
    end else if (mac_req) begin
      gnt[G_MAC] = 1'b1;
    end else if (instr_req) begin
      gnt[G_INSTR] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // SRAM command mux. These outputs are purely combinational on the requests,
  // so they keep following the inputs even while rstz is low.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_en    = instr_req | data_req | mac_req;
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    mem_mask  = 4'h0;
    if (gnt[G_DATA]) begin
      mem_wr_en = data_wr_en;
      mem_addr  = data_addr;
      mem_wdata = data_wr_data;
      mem_mask  = data_mask;
    end else if (gnt[G_MAC]) begin
      mem_addr  = mac_addr;
      mem_mask  = 4'hF;
    end else if (gnt[G_INSTR]) begin
      mem_addr  = instr_addr;
      mem_mask  = 4'hF;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered grant. store_q remembers whether the data grant was a write, so
  // that a store ack does not pass stale SRAM output back as load data.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      gnt_q   <= 3'b000;
      store_q <= 1'b0;
    end else begin
      gnt_q   <= gnt;
      store_q <= gnt[G_DATA] & data_wr_en;
    end
  end

  assign data_ack  = gnt_q[G_DATA];
  assign mac_ack   = gnt_q[G_MAC];
  assign instr_ack = gnt_q[G_INSTR];

  assign data_rd_data = (data_ack && !store_q) ? mem_rdata : 32'h0;
  assign mac_rdata    = mac_ack                ? mem_rdata : 32'h0;
  assign instr_data   = instr_ack              ? mem_rdata : 32'h0;

  // ---------------------------------------------------------------------------
  // Fetch starvation counter: counts consecutive cycles in which fetch asked
  // and lost. It saturates at MAX_WAIT, which is the level that arms the boost.
  // With MAX_WAIT = 0 it is held at zero.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      starve_cnt <= '0;
    end else if (!instr_req || gnt[G_INSTR]) begin
      starve_cnt <= '0;
    end else if (BOOST_EN && (starve_cnt != WAIT_MAX)) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

`ifdef MEM_ARB_STATS_EN
  // ---------------------------------------------------------------------------
  // Stall statistics: one saturating counter per port. stat_clr takes
  // priority over a stall in the same cycle.
  // ---------------------------------------------------------------------------
  logic [2:0] stall;
  assign stall[G_DATA]  = data_req  & ~gnt[G_DATA];
  assign stall[G_MAC]   = mac_req   & ~gnt[G_MAC];
  assign stall[G_INSTR] = instr_req & ~gnt[G_INSTR];

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      stat_data_stall  <= 32'h0;
      stat_mac_stall   <= 32'h0;
      stat_instr_stall <= 32'h0;
    end else if (stat_clr) begin
      stat_data_stall  <= 32'h0;
      stat_mac_stall   <= 32'h0;
      stat_instr_stall <= 32'h0;
    end else begin
      if (stall[G_DATA] && (stat_data_stall != 32'hFFFF_FFFF)) begin
        stat_data_stall <= stat_data_stall + 32'd1;
      end
      if (stall[G_MAC] && (stat_mac_stall != 32'hFFFF_FFFF)) begin
        stat_mac_stall <= stat_mac_stall + 32'd1;
      end
      if (stall[G_INSTR] && (stat_instr_stall != 32'hFFFF_FFFF)) begin
        stat_instr_stall <= stat_instr_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed scenarios followed by randomized traffic. A behavioural reference
// (priority list, denied-cycle count, shadow memory) predicts each cycle's
// SRAM command and the following cycle's acks and read data. A small SRAM
// model drives mem_rdata.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW       = 32;
  localparam int MAX_WAIT = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rstz;
  always #5 clk = ~clk;

  logic          instr_req, data_req, mac_req;
  logic [AW-1:0] instr_addr, data_addr, mac_addr;
  logic          data_wr_en;
  logic [3:0]    data_mask;
  logic [31:0]   data_wr_data;
  logic [31:0]   instr_data, data_rd_data, mac_rdata;
  logic          instr_ack, data_ack, mac_ack;
  logic          mem_en, mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_mask;
  logic [31:0]   mem_rdata;
`ifdef MEM_ARB_STATS_EN
  logic          stat_clr;
  logic [31:0]   stat_instr_stall, stat_data_stall, stat_mac_stall;
`endif

  mem_port_arbiter #(.AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk          (clk),
    .rstz         (rstz),
    .instr_req    (instr_req),
    .instr_addr   (instr_addr),
    .instr_data   (instr_data),
    .instr_ack    (instr_ack),
    .data_req     (data_req),
    .data_addr    (data_addr),
    .data_wr_en   (data_wr_en),
    .data_mask    (data_mask),
    .data_wr_data (data_wr_data),
    .data_rd_data (data_rd_data),
    .data_ack     (data_ack),
    .mac_req      (mac_req),
    .mac_addr     (mac_addr),
    .mac_rdata    (mac_rdata),
    .mac_ack      (mac_ack),
    .mem_en       (mem_en),
    .mem_wr_en    (mem_wr_en),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_mask     (mem_mask),
`ifdef MEM_ARB_STATS_EN
    .stat_clr         (stat_clr),
    .stat_instr_stall (stat_instr_stall),
    .stat_data_stall  (stat_data_stall),
    .stat_mac_stall   (stat_mac_stall),
`endif
    .mem_rdata    (mem_rdata)
  );

  // ---------------------------------------------------------------------------
  // SRAM model: 256 words, byte-masked write, registered read.
  // ---------------------------------------------------------------------------
  logic [31:0] sram [0:255];
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= sram[mem_addr[9:2]];
      if (mem_wr_en) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_mask[b]) sram[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard and reference state
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  // Entry: {instr_ack, data_ack, mac_ack, read_data}
  logic [34:0] exp_q [$];
  logic [31:0] ref_mem [0:255];
  int          denied;  // consecutive cycles fetch asked and lost
  int          st_i, st_d, st_m;

  // Values observed at the most recent step, for directed checks.
  logic        obs_ia, obs_da, obs_ma;
  logic [31:0] obs_idata, obs_ddata, obs_mdata;
  logic [31:0] obs_st_i, obs_st_d;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive_idle();
    instr_req = 0; instr_addr = '0;
    data_req = 0; data_addr = '0; data_wr_en = 0; data_mask = 4'h0; data_wr_data = 0;
    mac_req = 0; mac_addr = '0;
`ifdef MEM_ARB_STATS_EN
    stat_clr = 0;
`endif
  endtask

  task automatic drive_random();
    instr_req    = ($urandom_range(0, 99) < 60);
    data_req     = ($urandom_range(0, 99) < 45);
    mac_req      = ($urandom_range(0, 99) < 55);
    instr_addr   = AW'($urandom_range(0, 255) * 4);
    data_addr    = AW'($urandom_range(0, 255) * 4);
    mac_addr     = AW'($urandom_range(0, 255) * 4);
    data_wr_en   = $urandom_range(0, 1);
    data_mask    = 4'($urandom_range(0, 15));
    data_wr_data = $urandom;
`ifdef MEM_ARB_STATS_EN
    stat_clr     = ($urandom_range(0, 99) < 3);
`endif
  endtask

  // One clock cycle: at the falling edge check the previous cycle's acks and
  // this cycle's SRAM command against the reference, then advance.
  task automatic step();
    int          win;  // 0 none, 1 data, 2 mac, 3 instr
    int          order [3];
    logic [1:0]  reqs [1:3];
    logic [34:0] e;
    logic [31:0] rd;
    logic [AW-1:0] a;
    logic [3:0]  m;
    int          idx;

    @(negedge clk);
    obs_ia = instr_ack; obs_da = data_ack; obs_ma = mac_ack;
    obs_idata = instr_data; obs_ddata = data_rd_data; obs_mdata = mac_rdata;
`ifdef MEM_ARB_STATS_EN
    obs_st_i = stat_instr_stall; obs_st_d = stat_data_stall;
    check_eq("stat_instr", stat_instr_stall, st_i);
    check_eq("stat_data",  stat_data_stall,  st_d);
    check_eq("stat_mac",   stat_mac_stall,   st_m);
`else
    obs_st_i = 0; obs_st_d = 0;
`endif

    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("instr_ack", instr_ack, e[34]);
      check_eq("data_ack",  data_ack,  e[33]);
      check_eq("mac_ack",   mac_ack,   e[32]);
      check_eq("instr_data",   instr_data,   e[34] ? e[31:0] : 32'h0);
      check_eq("data_rd_data", data_rd_data, e[33] ? e[31:0] : 32'h0);
      check_eq("mac_rdata",    mac_rdata,    e[32] ? e[31:0] : 32'h0);
    end

    // Priority list: boosted fetch first, otherwise data, mac, instr.
    if (MAX_WAIT != 0 && denied == MAX_WAIT) order = '{3, 1, 2};
    else                                     order = '{1, 2, 3};
    reqs[1] = {1'b0, data_req};
    reqs[2] = {1'b0, mac_req};
    reqs[3] = {1'b0, instr_req};
    win = 0;
    for (int k = 0; k < 3; k++) begin
      if (win == 0 && reqs[order[k]][0]) win = order[k];
    end

    a  = (win == 1) ? data_addr : (win == 2) ? mac_addr : (win == 3) ? instr_addr : '0;
    m  = (win == 1) ? data_mask : (win != 0) ? 4'hF : 4'h0;
    check_eq("mem_en",    mem_en, instr_req | data_req | mac_req);
    check_eq("mem_addr",  mem_addr, a);
    check_eq("mem_wr_en", mem_wr_en, (win == 1) && data_wr_en);
    if (win != 0) check_eq("mem_mask", mem_mask, m);
    if (win == 1 && data_wr_en) check_eq("mem_wdata", mem_wdata, data_wr_data);

    idx = int'(a[9:2]);
    rd  = ref_mem[idx];
    if (win == 1 && data_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (m[b]) ref_mem[idx][b*8 +: 8] = data_wr_data[b*8 +: 8];
      end
      rd = 32'h0;
    end
    exp_q.push_back({win == 3, win == 1, win == 2, rd});

    if (instr_req && win != 3) denied = (denied < MAX_WAIT) ? denied + 1 : MAX_WAIT;
    else                        denied = 0;

`ifdef MEM_ARB_STATS_EN
    if (stat_clr) begin
      st_i = 0; st_d = 0; st_m = 0;
    end else begin
      if (instr_req && win != 3) st_i++;
      if (data_req  && win != 1) st_d++;
      if (mac_req   && win != 2) st_m++;
    end
`endif

    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int n_mac_first, n_instr_acks;
  bit seen_instr;

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = $urandom;
      sram[i]    = ref_mem[i];
    end
    ref_mem[16] = 32'h0000_0013;
    sram[16]    = 32'h0000_0013;
    denied = 0; st_i = 0; st_d = 0; st_m = 0;
    mem_rdata = 32'h0;

    rstz = 1'b0;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_instr_ack", instr_ack, 1'b0);
    check_eq("reset_data_ack",  data_ack,  1'b0);
    check_eq("reset_mac_ack",   mac_ack,   1'b0);
    rstz = 1'b1;
    step();

    // Single fetch of word 0x40.
    drive_idle(); instr_req = 1; instr_addr = 32'h40;
    step();
    drive_idle();
    step();
    check_eq("fetch_ack",  obs_ia, 1'b1);
    check_eq("fetch_data", obs_idata, 32'h0000_0013);
    check_eq("fetch_other_acks", {obs_da, obs_ma}, 2'b00);

    // Store competing with a fetch: data wins.
    drive_idle();
    data_req = 1; data_addr = 32'h3C0; data_wr_en = 1; data_mask = 4'hF;
    data_wr_data = 32'h400; instr_req = 1; instr_addr = 32'h80;
    step();
    drive_idle();
    step();
    check_eq("store_ack",       obs_da, 1'b1);
    check_eq("store_fetch_ack", obs_ia, 1'b0);
    check_eq("store_rd_data",   obs_ddata, 32'h0);
    check_eq("store_sram",      sram[240], 32'h400);

    // MAC streaming with a held fetch: fetch gets every 9th grant.
    drive_idle();
    step();
    mac_req = 1; mac_addr = 32'h100; instr_req = 1; instr_addr = 32'h44;
    n_mac_first = 0; n_instr_acks = 0; seen_instr = 0;
    for (int i = 0; i < 28; i++) begin
      step();
      if (obs_ia) begin
        seen_instr = 1;
        n_instr_acks++;
      end else if (obs_ma && !seen_instr) begin
        n_mac_first++;
      end
    end
    check_eq("starve_mac_before_boost", n_mac_first, 8);
    check_eq("starve_instr_acks",       n_instr_acks, 3);

    // Three-way tie without boost: only data is acked.
    drive_idle();
    step();
    data_req = 1; data_addr = 32'h20; mac_req = 1; mac_addr = 32'h24;
    instr_req = 1; instr_addr = 32'h28;
    step();
    drive_idle();
    step();
    check_eq("tie_acks", {obs_ia, obs_da, obs_ma}, 3'b010);

    // Reset while a MAC grant is pending: no ack may come out of it.
    drive_idle(); mac_req = 1; mac_addr = 32'h10;
    @(negedge clk);
    check_eq("rst_mem_en",   mem_en, 1'b1);
    check_eq("rst_mem_addr", mem_addr, 32'h10);
    rstz = 1'b0;
    #1;
    check_eq("rst_async_acks", {instr_ack, data_ack, mac_ack}, 3'b000);
    check_eq("rst_mem_follows", mem_addr, 32'h10);
    exp_q.delete();
    denied = 0; st_i = 0; st_d = 0; st_m = 0;
    @(posedge clk);
    #1;
    check_eq("rst_mac_ack", mac_ack, 1'b0);
    rstz = 1'b1;
    step();
    drive_idle();
    step();
    check_eq("post_rst_mac_ack",  obs_ma, 1'b1);
    check_eq("post_rst_mac_data", obs_mdata, ref_mem[4]);

`ifdef MEM_ARB_STATS_EN
    // Stall counters: fetch loses to data for five cycles.
    drive_idle(); stat_clr = 1;
    step();
    drive_idle(); data_req = 1; data_addr = 32'h8; instr_req = 1; instr_addr = 32'hC;
    repeat (5) step();
    drive_idle();
    step();
    check_eq("stat_instr_5", obs_st_i, 32'd5);
    check_eq("stat_data_0",  obs_st_d, 32'd0);
    stat_clr = 1;
    step();
    stat_clr = 0;
    step();
    check_eq("stat_clr_instr", obs_st_i, 32'd0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      drive_random();
      step();
    end
    drive_idle();
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates a single-port synchronous SRAM between three requesters: core data port (loads/stores), MAC coprocessor read port, and core instruction fetch.
- Replaces the ad-hoc combinational "data has priority" glue around the shared memory.
- Registers grant and ack so ack aligns with SRAM read data.
- Adds starvation protection for instruction fetch while the MAC streams operands.

Parameters:
- AW, 32, address width of all ports.
- MAX_WAIT, 8, consecutive denied cycles of instr_req before fetch is forced to top priority; 0 disables the boost.

Ports:
- clk  in  1  clock
- rstz  in  1  asynchronous active-low reset
- instr_req  in  1  fetch request (level)
- instr_addr  in  AW  fetch address
- instr_data  out  32  fetch read data, valid with instr_ack
- instr_ack  out  1  fetch completion
- data_req  in  1  load/store request
- data_addr  in  AW  load/store address
- data_wr_en  in  1  1 = store
- data_mask  in  4  byte mask for store
- data_wr_data  in  32  store data
- data_rd_data  out  32  load data, valid with data_ack
- data_ack  out  1  load/store completion
- mac_req  in  1  MAC operand read request
- mac_addr  in  AW  MAC read address
- mac_rdata  out  32  MAC read data, valid with mac_ack
- mac_ack  out  1  MAC read completion
- mem_en  out  1  SRAM enable
- mem_wr_en  out  1  SRAM write enable
- mem_addr  out  AW  SRAM address
- mem_wdata  out  32  SRAM write data
- mem_mask  out  4  SRAM byte mask
- mem_rdata  in  32  SRAM read data, one cycle after mem_en

Behaviour:
- Request protocol:
  - Level-based. Every cycle a req is high and the port is granted counts as one transaction.
  - Ack is asserted exactly one cycle after the grant cycle.
  - A req held high through its ack cycle is a new back-to-back request.
- Grant (combinational on the current cycle's reqs):
  - Normal priority: data > mac > instr.
  - Boost: if starve_cnt == MAX_WAIT and MAX_WAIT != 0, instr > data > mac for that cycle.
- SRAM drive:
  - mem_en = OR of all reqs.
  - mem_addr, mem_wdata and mem_mask come from the granted port.
  - mem_wr_en = data_wr_en & data granted.
  - mem_mask = 4'hF for non-data grants.
  - With no request: mem_addr = 0, mem_wr_en = 0.
- Registered state:
  - gnt_q[2:0], one-hot (data, mac, instr), = grant of the previous cycle.
  - data_ack = gnt_q[data], mac_ack = gnt_q[mac], instr_ack = gnt_q[instr].
  - At most one ack is high per cycle.
  - Reset value of gnt_q and all acks: 0.
- Read data:
  - instr_data, data_rd_data and mac_rdata are each mem_rdata when their ack is high, else 0.
  - A store ack carries data_rd_data = 0.
- Starvation counter starve_cnt (width clog2(MAX_WAIT+1)):
  - Increments when instr_req & ~instr granted, saturating at MAX_WAIT.
  - Clears when instr is granted or instr_req = 0.
  - Reset value 0.
- Simultaneous events:
  - All three reqs high with boost inactive: data wins; mac and instr see no ack.
  - If a store and a boosted fetch coincide, fetch wins and the store is retried by the requester (req stays high).
- Reset mid-operation:
  - rstz low clears gnt_q, acks and starve_cnt immediately (async).
  - A grant issued in the cycle before reset produces no ack.
  - Outputs derived combinationally from reqs (mem_*) follow the inputs regardless of reset.
- Latency: 1 cycle, req-granted to ack. Throughput: 1 transaction per cycle total.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- When defined, adds three outputs: stat_instr_stall, stat_data_stall, stat_mac_stall, each 32 bits.
  - Each counts cycles with req high and the port not granted.
  - Counters saturate at 32'hFFFF_FFFF; reset to 0.
  - Adds input stat_clr, 1 bit, synchronous clear of all three counters.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single fetch: instr_req=1, instr_addr=0x40 for one cycle, MEM[0x40>>2]=0x00000013 -> mem_en=1, mem_addr=0x40 that cycle; next cycle instr_ack=1, instr_data=0x00000013, other acks 0.
- Data vs fetch: data_req=1 store (addr 0x3C0, wdata 0x400, mask 4'hF) with instr_req=1 -> mem_wr_en=1, mem_addr=0x3C0; next cycle data_ack=1, instr_ack=0; MEM[240]=0x400.
- MAC vs fetch starvation, MAX_WAIT=8: mac_req and instr_req held high continuously -> 8 mac_acks, then grant goes to instr on cycle 9 (instr_ack cycle 10), then mac resumes; repeats every 9 grants.
- Three-way tie, boost inactive: all reqs high for one cycle -> only data_ack next cycle; starve_cnt = 1.
- Reset mid-op: grant mac at cycle N, assert rstz=0 before edge N+1 -> mac_ack stays 0; after release the first request is acked normally.
- MEM_ARB_STATS_EN: data and instr both high for 5 cycles (MAX_WAIT=8) -> stat_instr_stall=5, stat_data_stall=0; pulse stat_clr -> all counters 0 next cycle.
